// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, default geometry and counter sizing for
// the 32-bit to 16-bit asynchronous SRAM data-memory controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR     = 32'd1024;
  localparam int unsigned DEF_SRAM_ADDR_W   = 18;
  localparam int unsigned DEF_ACCESS_CYCLES = 3;
  localparam int unsigned SRAM_DATA_W       = 16;

  // Cycle counter width: ceil(log2(cycles)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit load/store into two timed 16-bit SRAM
// half-accesses (LO then HI). Optional macro SRAM_POSTED_WRITE_EN posts writes.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
  parameter int unsigned SRAM_ADDR_W   = DEF_SRAM_ADDR_W,
  parameter int unsigned ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  inout  wire  [15:0]            sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output state_t                 dbg_state
);

  localparam int unsigned CW = cnt_width(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  // Valid/ready: a request is accepted only in IDLE; ready=1 means the pipeline
  // may advance, so the request held during DONE is never re-accepted.
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   is_wr_q, is_wr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [SRAM_ADDR_W-2:0] word_q, word_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_q, oe_d;
  logic [15:0]            dq_out_q, dq_out_d;

  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] word_in;
  logic                   unused_bits;

  assign offset      = address - BASE_ADDR;
  assign word_in     = offset[SRAM_ADDR_W:2];
  assign unused_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    ready   = 1'b0;

    case (state_q)
      IDLE: begin
        ready = ~rd_en & ~wr_en;
        if (rd_en | wr_en) begin
          state_d = LO;
          cnt_d   = '0;
          is_wr_d = wr_en;
          wdata_d = wdata;
          word_d  = word_in;
          addr_d  = {word_in, 1'b0};
`ifdef SRAM_POSTED_WRITE_EN
          if (wr_en) ready = 1'b1;
`endif
        end
      end
      LO: begin
        if (cnt_q == LAST) begin
          state_d = HI;
          cnt_d   = '0;
          addr_d  = {word_q, 1'b1};
          if (!is_wr_q) rdata_d[15:0] = sram_dq;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HI: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!is_wr_q) rdata_d[31:16] = sram_dq;
`ifdef SRAM_POSTED_WRITE_EN
          state_d = is_wr_q ? IDLE : DONE;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus controls are registered from next-state values so the strobe is glitch-free;
    // we_n rises on the last cycle of each half to give address/data hold.
    oe_d     = is_wr_d & ((state_d == LO) | (state_d == HI));
    we_n_d   = ~(oe_d & (cnt_d != LAST));
    dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      we_n_q   <= we_n_d;
      oe_q     <= oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign sram_dq   = oe_q ? dq_out_q : 16'hzzzz;
  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: vector table, multi-cycle corner sequences and random
// traffic checked against a word-level memory model and a halfword SRAM model.
`timescale 1ns/1ps
module tb_sram_controller;
  import sram_pkg::*;

  localparam logic [31:0] BASE = 32'd1024;
  localparam int AW  = 18;
  localparam int AC  = 3;
  localparam int LAT = 2 * AC + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0]   address = '0, wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;
  state_t        dbg_state;

  logic          probe = 1'b0, sram_drive = 1'b0;
  logic [15:0]   sram_out = '0;
  logic          tb_oe;
  logic [15:0]   tb_dq;
  logic [15:0]   mem [int];
  logic [31:0]   ref_mem [logic [31:0]];
  logic [31:0]   last_rd = '0;
  int            checks = 0, failures = 0;

  sram_controller #(.BASE_ADDR(BASE), .SRAM_ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_dq(sram_dq),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // Probe drives zero: any nonzero value seen then means the DUT is driving too.
  always_comb begin
    tb_oe = probe | sram_drive;
    tb_dq = probe ? 16'h0000 : sram_out;
  end
  assign sram_dq = tb_oe ? tb_dq : 16'hzzzz;

  // Halfword SRAM: stores while the strobe is low, presents the addressed cell.
  always @(negedge clk) begin
    if (!sram_we_n && !sram_ce_n) mem[int'(sram_addr)] = sram_dq;
    sram_out = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 16'h0000;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  // ---- scoreboard helpers ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a - BASE) >> 2;
  endfunction

  task automatic check_dq_z(input string name);
    probe = 1'b1;
    #1 check(name, 32'(sram_dq), 32'h0);
    probe = 1'b0;
  endtask

  // ---- driver: one request from the next cycle; returns rdata at the ready cycle ----
  task automatic run_txn(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input bit keep, output logic [31:0] got);
    logic [31:0]   word;
    logic [AW-1:0] lo_a, hi_a;
    bit            posted;
    word   = word_of(a);
    lo_a   = AW'((word % (32'd1 << (AW - 1))) * 2);
    hi_a   = lo_a + 1'b1;
    posted = 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
    posted = w;
`endif
    @(negedge clk); #1;
    wr_en = w; rd_en = r; address = a; wdata = d; sram_drive = ~w;
    #1 check("ready_cycle0", 32'(ready), 32'(posted));
    if (posted) begin
      wr_en = 1'b0; rd_en = 1'b0;
    end
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk); #1;
      if (c <= 2 * AC) begin
        bit hi;
        int pos;
        hi  = (c > AC);
        pos = (c - 1) % AC;
        check(hi ? "addr_hi" : "addr_lo", 32'(sram_addr), hi ? 32'(hi_a) : 32'(lo_a));
        check("ready_busy", 32'(ready), 32'h0);
        check("we_n", 32'(sram_we_n), (w && pos != AC - 1) ? 32'h0 : 32'h1);
      end else begin
        check("ready_done", 32'(ready), 32'h1);
        got = rdata;
      end
    end
    if (!keep) begin
      wr_en = 1'b0; rd_en = 1'b0;
    end
    sram_drive = 1'b0;
    if (w) begin
      check("sram_lo_half", 32'(mem.exists(int'(lo_a)) ? mem[int'(lo_a)] : 16'hxxxx), 32'(d[15:0]));
      check("sram_hi_half", 32'(mem.exists(int'(hi_a)) ? mem[int'(hi_a)] : 16'hxxxx), 32'(d[31:16]));
      check_dq_z("dq_z_after_write");
    end
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] got;

  initial begin
    // Directed vectors; exp is rdata at the ready cycle (held across writes).
    tbl[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000};
    tbl[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'h12345678};
    tbl[4] = '{1'b1, 1'b0, 32'd1035, 32'hCAFEF00D, 32'h12345678};
    tbl[5] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'hCAFEF00D};
    tbl[6] = '{1'b1, 1'b0, 32'd0,    32'h0BADF00D, 32'hCAFEF00D};
    tbl[7] = '{1'b0, 1'b1, 32'd3,    32'h0,        32'h0BADF00D};

    // ---- reset then idle ----
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check_dq_z("rst_dq_z");
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, 1'b0, got);
      check($sformatf("vec%0d_rdata", i), got, tbl[i].exp);
      if (tbl[i].w) ref_mem[word_of(tbl[i].a)] = tbl[i].d;
      else last_rd = tbl[i].exp;
    end

    // ---- back-to-back: first read held through DONE must not repeat ----
    run_txn(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, got);
    check("b2b_first", got, ref_mem[32'd0]);
    run_txn(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, got);
    check("b2b_second", got, ref_mem[32'd2]);
    last_rd = ref_mem[32'd2];
    @(negedge clk); #1;
    check("b2b_idle_state", 32'(dbg_state), 32'(IDLE));
    check("b2b_idle_ready", 32'(ready), 32'h1);

    // ---- reset in the second LO cycle of a write ----
    @(negedge clk); #1;
    wr_en = 1'b1; address = BASE + 32'd80; wdata = 32'hA5A55A5A;
    repeat (2) @(negedge clk);
    #1 check("midrst_we_low", 32'(sram_we_n), 32'h0);
    rst = 1'b1; wr_en = 1'b0;
    @(negedge clk); #1;
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_we_n", 32'(sram_we_n), 32'h1);
    check("midrst_ready", 32'(ready), 32'h1);
    check("midrst_rdata", rdata, 32'h0);
    check_dq_z("midrst_dq_z");
    rst = 1'b0;
    last_rd = 32'h0;

    // ---- randomized traffic vs. word-level model ----
    for (int n = 0; n < 40; n++) begin
      logic [31:0] w_idx, a, d;
      bit          do_wr, both, keep;
      w_idx = 32'($urandom_range(0, 15));
      a     = BASE + w_idx * 4 + 32'($urandom_range(0, 3));
      d     = $urandom;
      do_wr = !ref_mem.exists(w_idx) || ($urandom_range(0, 1) == 1);
      both  = do_wr && ($urandom_range(0, 3) == 0);
      keep  = ($urandom_range(0, 1) == 1);
      run_txn(do_wr, !do_wr || both, a, d, keep, got);
      if (do_wr) begin
        check("rand_rdata_hold", got, last_rd);
        ref_mem[w_idx] = d;
      end else begin
        check("rand_read", got, ref_mem[w_idx]);
        last_rd = ref_mem[w_idx];
      end
    end

`ifdef SRAM_POSTED_WRITE_EN
    // ---- posted write followed by a read that must wait ----
    @(negedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk); #1;
    wr_en = 1'b1; address = BASE + 32'd120; wdata = 32'h600DCAFE;
    #1 check("posted_ready_c0", 32'(ready), 32'h1);
    for (int c = 1; c <= 2 * LAT; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        wr_en = 1'b0; rd_en = 1'b1;
      end
      if (c == LAT) sram_drive = 1'b1;
      #1 check("posted_ready", 32'(ready), (c == 2 * LAT) ? 32'h1 : 32'h0);
    end
    check("posted_read", rdata, 32'h600DCAFE);
    rd_en = 1'b0; sram_drive = 1'b0;
`endif

    // ---- report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
